// File: rtl/sustain_envelope_ctrl.sv
// Sustain control: debounces and quantises a user control into a sustain code,
// then runs an attack / sustain-hold / release amplitude envelope from a note gate.
module sustain_envelope_ctrl #(
    parameter int IN_W         = 10,
    parameter int CODE_W       = 4,
    parameter int AMP_W        = 8,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_CYC   = 3,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gate,
    input  logic [IN_W-1:0]   user_input0,
    output logic [CODE_W-1:0] sustainTime,
    output logic [AMP_W-1:0]  amplitude,
    output logic [1:0]        env_state,
    output logic              env_active
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = $clog2(STABLE_CYC + 1);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(STABLE_CYC);
    localparam logic [AMP_W:0]    AMP_MAX     = {1'b0, {AMP_W{1'b1}}};
    localparam logic [AMP_W:0]    ATTACK_INC  = (AMP_W + 1)'(ATTACK_STEP);
    localparam logic [AMP_W:0]    RELEASE_DEC = (AMP_W + 1)'(RELEASE_STEP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    // ------------------------------------------------------------------
    // Quantiser and stability filter
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] q;
    logic [CODE_W-1:0] candidate_reg, candidate_next;
    logic [CODE_W-1:0] sustain_reg, sustain_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    assign q = CODE_W'(user_input0 >> (IN_W - CODE_W));

    always_comb begin
        candidate_next = candidate_reg;
        count_next     = count_reg;
        sustain_next   = sustain_reg;
        if (q != candidate_reg) begin
            candidate_next = q;
            count_next     = CNT_W'(1);
        end else if (count_reg != CNT_FULL) begin
            count_next = count_reg + CNT_W'(1);
        end
        // A run of STABLE_CYC identical samples commits the code.
        if (count_next == CNT_FULL) begin
            sustain_next = candidate_next;
        end
    end

    // ------------------------------------------------------------------
    // Envelope tick and gate edge detection
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic              tick;
    logic              gate_q_reg;
    logic              rise;
    logic              fall;

    assign tick          = (tick_cnt_reg == TICK_LAST);
    assign tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_W'(1);
    assign rise          = gate & ~gate_q_reg;
    assign fall          = ~gate & gate_q_reg;

    // ------------------------------------------------------------------
    // Envelope FSM
    // ------------------------------------------------------------------
    env_state_t        state_reg, state_next;
    logic [AMP_W-1:0]  amp_reg, amp_next;
    logic [CODE_W-1:0] hold_reg, hold_next;
    logic [AMP_W:0]    amp_sum;
    logic [AMP_W:0]    amp_diff;

    // One spare bit exposes overflow on attack and borrow on release.
    assign amp_sum  = {1'b0, amp_reg} + ATTACK_INC;
    assign amp_diff = {1'b0, amp_reg} - RELEASE_DEC;

    always_comb begin
        state_next = state_reg;
        amp_next   = amp_reg;
        hold_next  = hold_reg;
        if (rise) begin
            // Retrigger keeps the current level so a release is not cut to 0.
            state_next = ST_ATTACK;
        end else begin
            case (state_reg)
                ST_ATTACK: begin
                    if (fall) begin
                        state_next = ST_RELEASE;
                    end else if (tick) begin
                        if (amp_sum >= AMP_MAX) begin
                            amp_next   = {AMP_W{1'b1}};
                            state_next = ST_SUSTAIN;
                            hold_next  = sustain_reg;
                        end else begin
                            amp_next = amp_sum[AMP_W-1:0];
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate_q_reg || fall) begin
                        state_next = ST_RELEASE;
                    end else if (tick && (hold_reg != '0)) begin
                        // A zero hold means sustain until the gate drops.
                        if (hold_reg == CODE_W'(1)) begin
                            state_next = ST_RELEASE;
                        end else begin
                            hold_next = hold_reg - CODE_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (tick) begin
                        if (amp_diff[AMP_W] || (amp_diff == '0)) begin
                            amp_next   = '0;
                            state_next = ST_IDLE;
                        end else begin
                            amp_next = amp_diff[AMP_W-1:0];
                        end
                    end
                end
                default: begin
                    amp_next = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            candidate_reg <= '0;
            count_reg     <= '0;
            sustain_reg   <= '0;
            tick_cnt_reg  <= '0;
            gate_q_reg    <= 1'b0;
            state_reg     <= ST_IDLE;
            amp_reg       <= '0;
            hold_reg      <= '0;
        end else begin
            candidate_reg <= candidate_next;
            count_reg     <= count_next;
            sustain_reg   <= sustain_next;
            tick_cnt_reg  <= tick_cnt_next;
            gate_q_reg    <= gate;
            state_reg     <= state_next;
            amp_reg       <= amp_next;
            hold_reg      <= hold_next;
        end
    end

    assign sustainTime = sustain_reg;
    assign amplitude   = amp_reg;
    assign env_state   = state_reg;
    assign env_active  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sustain_envelope_ctrl.sv
// Scoreboard bench for sustain_envelope_ctrl: a behavioural model predicts every
// edge's outputs into a queue and a monitor pops and compares after each edge.
module tb_sustain_envelope_ctrl;

    localparam int IN_W         = 10;
    localparam int CODE_W       = 4;
    localparam int AMP_W        = 8;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_CYC   = 3;
    localparam int ATTACK_STEP  = 32;
    localparam int RELEASE_STEP = 16;
    localparam int AMP_TOP      = (1 << AMP_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              gate;
    logic [IN_W-1:0]   user_input0;
    logic [CODE_W-1:0] sustainTime;
    logic [AMP_W-1:0]  amplitude;
    logic [1:0]        env_state;
    logic              env_active;

    sustain_envelope_ctrl #(
        .IN_W(IN_W), .CODE_W(CODE_W), .AMP_W(AMP_W), .TICK_DIV(TICK_DIV),
        .STABLE_CYC(STABLE_CYC), .ATTACK_STEP(ATTACK_STEP), .RELEASE_STEP(RELEASE_STEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gate(gate),
        .user_input0(user_input0),
        .sustainTime(sustainTime),
        .amplitude(amplitude),
        .env_state(env_state),
        .env_active(env_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sustain;
        int amp;
        int state;
        int active;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (0 idle, 1 attack, 2 sustain, 3 release)
    int m_hist[$];
    int m_edges;
    int m_gate_prev;
    int m_state;
    int m_amp;
    int m_hold;
    int m_sustain;

    int compared   = 0;
    int mismatched = 0;

    task automatic model_edge();
        int  q;
        bit  tick;
        bit  rise;
        bit  fall;
        bit  same;
        if (reset) begin
            m_hist.delete();
            m_edges     = 0;
            m_gate_prev = 0;
            m_state     = 0;
            m_amp       = 0;
            m_hold      = 0;
            m_sustain   = 0;
        end else begin
            q    = int'(user_input0) / (1 << (IN_W - CODE_W));
            tick = ((m_edges % TICK_DIV) == TICK_DIV - 1);
            m_edges++;
            rise = gate && (m_gate_prev == 0);
            fall = !gate && (m_gate_prev != 0);
            if (rise) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (fall) m_state = 3;
                else if (tick) begin
                    m_amp = m_amp + ATTACK_STEP;
                    if (m_amp >= AMP_TOP) begin
                        m_amp   = AMP_TOP;
                        m_state = 2;
                        m_hold  = m_sustain;
                    end
                end
            end else if (m_state == 2) begin
                if (m_gate_prev == 0 || fall) m_state = 3;
                else if (tick && m_hold != 0) begin
                    if (m_hold == 1) m_state = 3;
                    else m_hold = m_hold - 1;
                end
            end else if (m_state == 3) begin
                if (tick) begin
                    m_amp = m_amp - RELEASE_STEP;
                    if (m_amp <= 0) begin
                        m_amp   = 0;
                        m_state = 0;
                    end
                end
            end else begin
                m_amp = 0;
            end
            m_gate_prev = gate ? 1 : 0;
            // The code commits once the last STABLE_CYC samples agree.
            m_hist.push_back(q);
            if (m_hist.size() > STABLE_CYC) void'(m_hist.pop_front());
            if (m_hist.size() == STABLE_CYC) begin
                same = 1'b1;
                foreach (m_hist[i]) if (m_hist[i] != q) same = 1'b0;
                if (same) m_sustain = q;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_edge();
        e.sustain = m_sustain;
        e.amp     = m_amp;
        e.state   = m_state;
        e.active  = (m_state != 0) ? 1 : 0;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Monitor: one comparison per clock edge
    exp_t mon_e;
    int   mon_cyc    = 0;
    int   last_state = -1;
    int   last_sus   = -1;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_cyc++;
            compared++;
            if ($isunknown({sustainTime, amplitude, env_state, env_active}) ||
                int'(sustainTime) != mon_e.sustain || int'(amplitude) != mon_e.amp ||
                int'(env_state) != mon_e.state || int'(env_active) != mon_e.active) begin
                mismatched++;
                $display("FAIL cycle %0d outputs: got sus=%0d amp=%0d st=%0d act=%0d, expected sus=%0d amp=%0d st=%0d act=%0d",
                         mon_cyc, sustainTime, amplitude, env_state, env_active,
                         mon_e.sustain, mon_e.amp, mon_e.state, mon_e.active);
            end else if (mon_e.state != last_state || mon_e.sustain != last_sus) begin
                $display("cycle %0d: sustainTime=%0d amplitude=%0d env_state=%0d env_active=%0d",
                         mon_cyc, sustainTime, amplitude, env_state, env_active);
            end
            last_state = mon_e.state;
            last_sus   = mon_e.sustain;
        end
    end

    initial begin
        int dur;

        // Reset with input and gate active
        reset       = 1'b1;
        gate        = 1'b1;
        user_input0 = IN_W'(600);
        run(2);
        reset = 1'b0;
        gate  = 1'b0;
        run(4);

        // Code stepping and a short glitch
        user_input0 = IN_W'(0);    run(3);
        user_input0 = IN_W'(300);  run(3);
        user_input0 = IN_W'(400);  run(3);
        user_input0 = IN_W'(500);  run(3);
        user_input0 = IN_W'(300);  run(3);
        user_input0 = IN_W'(1023); run(2);
        user_input0 = IN_W'(300);  run(3);

        // Full envelope with a hold of 4 ticks
        gate = 1'b1; run(130);
        gate = 1'b0; run(8);

        // Infinite hold with a zero code
        user_input0 = IN_W'(0); run(4);
        gate = 1'b1; run(440);
        gate = 1'b0; run(80);

        // Drop in attack, retrigger during release
        gate = 1'b1;
        for (int k = 0; k < 200 && m_amp != 96; k++) cycle();
        gate = 1'b0;
        for (int k = 0; k < 200 && m_amp != 48; k++) cycle();
        gate = 1'b1; run(12);
        gate = 1'b0; run(80);

        // Reset in the middle of sustain
        user_input0 = IN_W'(300); run(4);
        gate = 1'b1;
        for (int k = 0; k < 200 && m_state != 2; k++) cycle();
        run(3);
        reset = 1'b1; run(1);
        reset = 1'b0; run(40);

        // Randomised segments
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1; run(1);
                reset = 1'b0;
            end
            gate        = 1'($urandom_range(0, 1));
            user_input0 = IN_W'($urandom_range(0, (1 << IN_W) - 1));
            dur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 60));
            run(dur);
        end

        @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
